// File: rtl/ascon_pack.sv
// Shared types and constants for the unrolled Ascon permutation engine.
// The state packs {x0,x1,x2,x3,x4} with x0 in the most significant word.
package ascon_pack;

  typedef logic [63:0] u64_t;

  typedef struct packed {
    u64_t x0;
    u64_t x1;
    u64_t x2;
    u64_t x3;
    u64_t x4;
  } u320_t;

  localparam int ROUND_WIDTH      = 4;
  localparam int ASCON_MAX_ROUNDS = 12;

  // Constant for round i of p^12; p^a uses the last a entries.
  localparam logic [7:0] RndConst [ASCON_MAX_ROUNDS] = '{
    8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
    8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b
  };

  localparam logic [4:0] Sbox [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  // Linear-layer rotation pairs, indexed by word (0 = x0).
  localparam int unsigned RotA [5] = '{19, 61, 1, 10, 7};
  localparam int unsigned RotB [5] = '{28, 39, 6, 17, 41};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fsm_e;

  function automatic u64_t rotr(input u64_t x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational Ascon round: constant add, column S-box, linear diffusion.
// When en_i is low the stage is a pure pass-through.
module ascon_round
  import ascon_pack::*;
(
  input  u320_t      state_i,
  input  logic [7:0] const_i,
  input  logic       en_i,
  output u320_t      state_o
);

  u64_t       xa [5];
  u64_t       xs [5];
  u64_t       xl [5];
  logic [4:0] col;
  logic [4:0] sb;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can leave it unassigned and infer a latch.
    xs  = '{default: '0};
    col = '0;
    sb  = '0;
    xa[0] = state_i.x0;
    xa[1] = state_i.x1;
    xa[2] = state_i.x2 ^ {56'h0, const_i};
    xa[3] = state_i.x3;
    xa[4] = state_i.x4;
    for (int b = 0; b < 64; b++) begin
      col = {xa[0][b], xa[1][b], xa[2][b], xa[3][b], xa[4][b]};
      sb  = Sbox[col];
      for (int i = 0; i < 5; i++) xs[i][b] = sb[4-i];
    end
    for (int i = 0; i < 5; i++) xl[i] = xs[i] ^ rotr(xs[i], RotA[i]) ^ rotr(xs[i], RotB[i]);
  end

  always_comb begin
    state_o = state_i;
    if (en_i) state_o = '{x0: xl[0], x1: xl[1], x2: xl[2], x3: xl[3], x4: xl[4]};
  end

endmodule

// File: rtl/ascon_perm_unrolled.sv
// Self-sequencing Ascon p^a engine evaluating UNROLL rounds per clock,
// with valid/ready handshakes on both sides and a synchronous flush.
module ascon_perm_unrolled
  import ascon_pack::*;
#(
  parameter int UNROLL   = 1,
  parameter int OUT_GATE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [3:0]   rounds_i,
  input  logic [319:0] state_i,
  input  logic         flush_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [319:0] state_o,
  output logic         busy_o
);

  if (UNROLL != 1 && UNROLL != 2 && UNROLL != 3 && UNROLL != 4 && UNROLL != 6 && UNROLL != 12) begin : g_bad_unroll
    $error("ascon_perm_unrolled: UNROLL must be one of 1, 2, 3, 4, 6, 12");
  end

  localparam logic [ROUND_WIDTH-1:0] UnrollW = ROUND_WIDTH'(UNROLL);
  localparam logic [ROUND_WIDTH-1:0] MaxW    = ROUND_WIDTH'(ASCON_MAX_ROUNDS);

  fsm_e                   fsm_q, fsm_d;
  u320_t                  state_q, state_d;
  logic [ROUND_WIDTH-1:0] cnt_q, cnt_d;

  u320_t                  stage [UNROLL+1];
  logic [7:0]             rc [UNROLL];
  logic                   en [UNROLL];
  logic [ROUND_WIDTH:0]   rc_idx;
  logic [ROUND_WIDTH-1:0] rounds_a;
  logic                   last_step;
  logic                   take_in;

  // Stage j runs round cnt+j; stages past the last round fall through unchanged.
  always_comb begin
    rc_idx = '0;
    for (int j = 0; j < UNROLL; j++) begin
      rc_idx = {1'b0, cnt_q} + (ROUND_WIDTH+1)'(j);
      en[j]  = rc_idx < (ROUND_WIDTH+1)'(ASCON_MAX_ROUNDS);
      rc[j]  = en[j] ? RndConst[rc_idx[ROUND_WIDTH-1:0]] : 8'h00;
    end
  end

  assign stage[0] = state_q;

  for (genvar j = 0; j < UNROLL; j++) begin : g_round
    ascon_round u_round (
      .state_i (stage[j]),
      .const_i (rc[j]),
      .en_i    (en[j]),
      .state_o (stage[j+1])
    );
  end

  assign rounds_a  = (rounds_i > MaxW) ? MaxW : rounds_i;
  assign last_step = (MaxW - cnt_q) <= UnrollW;

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      fsm_q   <= ST_IDLE;
      state_q <= '0;
      cnt_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    take_in = 1'b0;
    if (flush_i) begin
      fsm_d = ST_IDLE;
      cnt_d = '0;
    end else begin
      case (fsm_q)
        ST_IDLE: take_in = in_valid_i;
        ST_RUN: begin
          state_d = stage[UNROLL];
          if (last_step) begin
            cnt_d = MaxW;
            fsm_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + UnrollW;
          end
        end
        ST_DONE: begin
          if (out_ready_i) begin
            fsm_d   = ST_IDLE;
            take_in = in_valid_i;
          end
        end
        default: fsm_d = ST_IDLE;
      endcase
      // A handoff in DONE and a new acceptance share one edge.
      if (take_in) begin
        state_d = state_i;
        cnt_d   = MaxW - rounds_a;
        fsm_d   = (rounds_a == '0) ? ST_DONE : ST_RUN;
      end
    end
  end

  always_comb begin
    in_ready_o  = (fsm_q == ST_IDLE) || ((fsm_q == ST_DONE) && out_ready_i);
    out_valid_o = (fsm_q == ST_DONE);
    busy_o      = (fsm_q == ST_RUN);
    state_o     = ((OUT_GATE != 0) && !out_valid_o) ? '0 : state_q;
  end

endmodule

// File: tb/tb_ascon_perm_unrolled.sv
// Bench for ascon_perm_unrolled: three instances (UNROLL 1/4/3) checked
// against a bit-sliced word-level Ascon model with random and directed stimulus.
module tb_ascon_perm_unrolled;

  localparam int N = 3;
  localparam int Unr [N] = '{1, 4, 3};
  localparam logic [319:0] IV = {64'h80400c0600000000, 256'h0};

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid  [N];
  logic         in_ready  [N];
  logic [3:0]   rounds    [N];
  logic [319:0] st_in     [N];
  logic         flush     [N];
  logic         out_valid [N];
  logic         out_ready [N];
  logic [319:0] st_out    [N];
  logic         busy      [N];

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  ascon_perm_unrolled #(.UNROLL(1), .OUT_GATE(1)) u_dut_u1 (
    .clk(clk), .rst(rst), .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
    .rounds_i(rounds[0]), .state_i(st_in[0]), .flush_i(flush[0]), .out_valid_o(out_valid[0]),
    .out_ready_i(out_ready[0]), .state_o(st_out[0]), .busy_o(busy[0]));

  ascon_perm_unrolled #(.UNROLL(4), .OUT_GATE(1)) u_dut_u4 (
    .clk(clk), .rst(rst), .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
    .rounds_i(rounds[1]), .state_i(st_in[1]), .flush_i(flush[1]), .out_valid_o(out_valid[1]),
    .out_ready_i(out_ready[1]), .state_o(st_out[1]), .busy_o(busy[1]));

  ascon_perm_unrolled #(.UNROLL(3), .OUT_GATE(0)) u_dut_u3 (
    .clk(clk), .rst(rst), .in_valid_i(in_valid[2]), .in_ready_o(in_ready[2]),
    .rounds_i(rounds[2]), .state_i(st_in[2]), .flush_i(flush[2]), .out_valid_o(out_valid[2]),
    .out_ready_i(out_ready[2]), .state_o(st_out[2]), .busy_o(busy[2]));

  // ---------------- reference model ----------------
  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Apply rounds first..first+n-1 of p^12 (round constant is ((15-r)<<4)|r).
  function automatic logic [319:0] p_rounds(input logic [319:0] s, input int first, input int n);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    {x0, x1, x2, x3, x4} = s;
    for (int r = first; r < first + n; r++) begin
      x2 ^= 64'(((15 - r) << 4) | r);
      x0 ^= x4; x4 ^= x3; x2 ^= x1;
      t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
      x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
      x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
      x0 ^= ror(x0, 19) ^ ror(x0, 28);
      x1 ^= ror(x1, 61) ^ ror(x1, 39);
      x2 ^= ror(x2, 1)  ^ ror(x2, 6);
      x3 ^= ror(x3, 10) ^ ror(x3, 17);
      x4 ^= ror(x4, 7)  ^ ror(x4, 41);
    end
    return {x0, x1, x2, x3, x4};
  endfunction

  function automatic int clamp_a(input int a);
    return (a > 12) ? 12 : a;
  endfunction

  function automatic logic [319:0] perm(input logic [319:0] s, input int a);
    return p_rounds(s, 12 - clamp_a(a), clamp_a(a));
  endfunction

  function automatic logic [319:0] rand320();
    logic [319:0] v;
    for (int i = 0; i < 10; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Full transaction: request, count edges to out_valid, compare, hand off.
  task automatic run_txn(input int d, input int a, input logic [319:0] s, input string tag);
    int           aa, steps, edges, busy_cnt;
    logic [319:0] exp;
    aa    = clamp_a(a);
    steps = (aa + Unr[d] - 1) / Unr[d];
    exp   = perm(s, a);
    @(negedge clk);
    check_int({tag, " in_ready idle"}, int'(in_ready[d]), 1);
    in_valid[d] = 1'b1;
    rounds[d]   = 4'(a);
    st_in[d]    = s;
    edges    = 0;
    busy_cnt = 0;
    do begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      in_valid[d] = 1'b0;
      st_in[d]    = rand320();
      if (busy[d]) busy_cnt++;
    end while (!out_valid[d] && edges < 25);
    // edges counts from the request edge, so the accepting edge is edge 1.
    check_int({tag, " edges to valid"}, edges, (aa == 0) ? 1 : steps + 1);
    check_int({tag, " busy cycles"}, busy_cnt, (aa == 0) ? 0 : steps);
    check({tag, " result"}, st_out[d], exp);
    out_ready[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready[d] = 1'b0;
    check_int({tag, " valid after handoff"}, int'(out_valid[d]), 0);
    if (d != 2) check({tag, " gated output"}, st_out[d], 320'h0);
  endtask

  initial begin
    logic [319:0] s1, s2, exp1;
    int           edges, vcnt;
    rst = 1'b1;
    for (int d = 0; d < N; d++) begin
      in_valid[d] = 1'b0; rounds[d] = '0; st_in[d] = '0; flush[d] = 1'b0; out_ready[d] = 1'b0;
    end

    // Reset state
    @(negedge clk);
    for (int d = 0; d < N; d++) begin
      check_int($sformatf("reset in_ready d%0d", d), int'(in_ready[d]), 1);
      check_int($sformatf("reset out_valid d%0d", d), int'(out_valid[d]), 0);
      check_int($sformatf("reset busy d%0d", d), int'(busy[d]), 0);
      check($sformatf("reset state_o d%0d", d), st_out[d], 320'h0);
    end
    rst = 1'b0;

    // Directed test-plan points
    run_txn(0, 12, IV, "u1 a12 iv");
    run_txn(1, 6, IV, "u4 a6 iv");
    run_txn(0, 6, IV, "u1 a6 iv");
    run_txn(2, 8, rand320(), "u3 a8");
    run_txn(2, 15, rand320(), "u3 a15");
    run_txn(2, 0, rand320(), "u3 a0");
    run_txn(1, 0, rand320(), "u4 a0");
    run_txn(0, 1, rand320(), "u1 a1");

    // Random transactions on every instance
    for (int i = 0; i < 4; i++)
      for (int d = 0; d < N; d++)
        run_txn(d, $urandom_range(0, 15), rand320(), $sformatf("rand i%0d d%0d", i, d));

    // Back-to-back on UNROLL=4: stalled result, then handoff + accept on one edge
    s1 = rand320();
    s2 = rand320();
    exp1 = perm(s1, 12);
    @(negedge clk);
    in_valid[1] = 1'b1; rounds[1] = 4'd12; st_in[1] = s1;
    @(posedge clk);
    @(negedge clk);
    in_valid[1] = 1'b0;
    edges = 0;
    while (!out_valid[1] && edges < 10) begin
      @(posedge clk);
      @(negedge clk);
      edges++;
    end
    check_int("b2b first latency", edges, 3);
    for (int c = 0; c < 5; c++) begin
      check_int($sformatf("b2b hold valid c%0d", c), int'(out_valid[1]), 1);
      check_int($sformatf("b2b hold in_ready c%0d", c), int'(in_ready[1]), 0);
      check($sformatf("b2b hold data c%0d", c), st_out[1], exp1);
      @(posedge clk);
      @(negedge clk);
    end
    out_ready[1] = 1'b1;
    in_valid[1]  = 1'b1; rounds[1] = 4'd5; st_in[1] = s2;
    #1;
    check_int("b2b in_ready on handoff", int'(in_ready[1]), 1);
    @(posedge clk);
    @(negedge clk);
    out_ready[1] = 1'b0;
    in_valid[1]  = 1'b0;
    check_int("b2b no idle: busy", int'(busy[1]), 1);
    check_int("b2b no idle: valid low", int'(out_valid[1]), 0);
    edges = 0;
    while (!out_valid[1] && edges < 10) begin
      @(posedge clk);
      @(negedge clk);
      edges++;
    end
    check_int("b2b second latency", edges, 2);
    check("b2b second result", st_out[1], perm(s2, 5));
    out_ready[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready[1] = 1'b0;

    // Flush in the 3rd RUN cycle on UNROLL=3, ungated output
    s1 = rand320();
    in_valid[2] = 1'b1; rounds[2] = 4'd12; st_in[2] = s1;
    @(posedge clk);
    @(negedge clk);
    in_valid[2] = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      @(negedge clk);
    end
    check_int("flush busy before", int'(busy[2]), 1);
    flush[2] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush[2] = 1'b0;
    check_int("flush in_ready", int'(in_ready[2]), 1);
    check_int("flush busy", int'(busy[2]), 0);
    check("flush state kept", st_out[2], p_rounds(s1, 0, 6));
    vcnt = 0;
    for (int c = 0; c < 15; c++) begin
      if (out_valid[2]) vcnt++;
      @(posedge clk);
      @(negedge clk);
    end
    check_int("flush valid never rises", vcnt, 0);
    run_txn(2, 4, rand320(), "after flush");

    // Flush over a pending result on UNROLL=1 (gated output)
    in_valid[0] = 1'b1; rounds[0] = 4'd1; st_in[0] = rand320();
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_int("done-flush valid before", int'(out_valid[0]), 1);
    flush[0] = 1'b1;
    in_valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush[0] = 1'b0;
    in_valid[0] = 1'b0;
    check_int("done-flush valid", int'(out_valid[0]), 0);
    check_int("done-flush busy", int'(busy[0]), 0);
    check("done-flush gated", st_out[0], 320'h0);

    // Asynchronous reset mid-RUN on UNROLL=3 (ungated: state register visible)
    in_valid[2] = 1'b1; rounds[2] = 4'd12; st_in[2] = rand320();
    @(posedge clk);
    @(negedge clk);
    in_valid[2] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_int("async rst busy before", int'(busy[2]), 1);
    #2 rst = 1'b1;
    #1;
    check_int("async rst busy", int'(busy[2]), 0);
    check_int("async rst in_ready", int'(in_ready[2]), 1);
    check_int("async rst valid", int'(out_valid[2]), 0);
    check("async rst state", st_out[2], 320'h0);
    @(negedge clk);
    rst = 1'b0;
    run_txn(2, 12, IV, "after rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
